uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_NUM_REQ   = 4;
    localparam int DEFAULT_MAX_BURST = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_vld
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;

    // Rotating the doubled vector puts requester ptr at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> ptr);

    // Scan downward so the lowest rotated offset is the last (winning) assignment.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (req_rot[k-1]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'((32'(ptr) + k - 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging NUM_REQ byte streams onto one UART transmit stream.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEFAULT_NUM_REQ,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 to_uart_data,
    output logic                       to_uart_valid,
    output logic                       to_uart_error,
    input  logic                       to_uart_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             granted;
    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic             beat;
    logic             release_beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Steer the owner's stream to the UART; reset gates it so no handshake completes on the reset edge.
    always_comb begin
        granted   = (state_q == GRANT) && !reset;
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDX_W'(i)) begin
                sel_data     = req_data[i*8 +: 8];
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                req_ready[i] = granted & to_uart_ready;
            end
        end
    end

    assign to_uart_data  = granted ? sel_data : '0;
    assign to_uart_valid = granted & sel_valid;
    assign to_uart_error = 1'b0;
    assign busy          = granted;
    assign grant_id      = grant_id_q;

    assign beat         = to_uart_valid & to_uart_ready;
    assign release_beat = beat & (sel_last |
                          ((MAX_BURST != 0) && ((burst_cnt_q + 1'b1) == BURST_LIMIT)));

    // Next-state: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if (release_beat) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=64).
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 64;
    localparam int SD = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      to_uart_data;
    logic            to_uart_valid;
    logic            to_uart_error;
    logic            to_uart_ready;
    logic [1:0]      grant_id;
    logic            busy;

    // Source streams: bytes queued per requester, consumed on handshake.
    logic [7:0]  s_data [NR][SD];
    logic        s_last [NR][SD];
    int          s_pos  [NR];
    int          s_len  [NR];
    logic [NR-1:0] hs_q = '0;

    // UART-side log of transferred beats.
    logic [7:0] log_d [256];
    int         log_g [256];
    int         log_n = 0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .to_uart_data  (to_uart_data),
        .to_uart_valid (to_uart_valid),
        .to_uart_error (to_uart_error),
        .to_uart_ready (to_uart_ready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    // Present the head byte of each requester's stream.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            if (s_pos[i] < s_len[i] && s_pos[i] < SD) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = s_data[i][s_pos[i]];
                req_last[i]        = s_last[i][s_pos[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // Sample handshakes mid-cycle and log UART beats.
    always @(negedge clk) begin
        hs_q = req_valid & req_ready;
        if (to_uart_valid && to_uart_ready && log_n < 256) begin
            log_d[log_n] = to_uart_data;
            log_g[log_n] = int'(grant_id);
            log_n++;
        end
    end

    // Advance sources just after the edge that completed their handshake.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs_q[i]) s_pos[i]++;
        end
    end

    task automatic load(input int r, input int n, input logic [7:0] base, input bit with_last);
        for (int k = 0; k < n; k++) begin
            s_data[r][s_len[r] + k] = base + 8'(k);
            s_last[r][s_len[r] + k] = with_last && (k == n - 1);
        end
        s_len[r] = s_len[r] + n;
    endtask

    task automatic wait_log(input int target, input int limit, output bit ok);
        int c = 0;
        while (log_n < target && c < limit) begin
            @(negedge clk); #1; c++;
        end
        ok = (log_n >= target);
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int c = 0;
        while (busy && c < limit) begin
            @(negedge clk); #1; c++;
        end
        ok = !busy;
    endtask

    task automatic reset_dut;
        @(posedge clk); #2;
        reset = 1'b1;
        to_uart_ready = 1'b1;
        for (int r = 0; r < NR; r++) s_len[r] = s_pos[r];
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset;
        bit ok;
        load(1, 1, 8'h31, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (to_uart_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", to_uart_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy); end
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
        tests_run++; if (to_uart_error !== 1'b0) begin tests_failed++; $display("FAIL rst_error: got %b expected 0", to_uart_error); end
        tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL rst_gid: got %0d expected 0", grant_id); end
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        tests_run++; if (to_uart_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_bubble: got valid=%b busy=%b expected 0 0", to_uart_valid, busy); end
        @(negedge clk);
        tests_run++; if (busy !== 1'b1 || grant_id !== 2'd1 || to_uart_data !== 8'h31 || req_ready !== 4'b0010)
            begin tests_failed++; $display("FAIL rst_first_grant: got busy=%b gid=%0d data=%h rdy=%b expected 1 1 31 0010", busy, grant_id, to_uart_data, req_ready); end
        #1 wait_idle(20, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rst_idle_timeout: got busy=%b expected 0", busy); end
    endtask

    task automatic test_single;
        logic [7:0] exp;
        reset_dut();
        load(2, 3, 8'h41, 1'b1);
        #1;
        tests_run++; if (to_uart_valid !== 1'b0 || req_ready !== 4'b0000)
            begin tests_failed++; $display("FAIL single_bubble: got valid=%b rdy=%b expected 0 0000", to_uart_valid, req_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = 8'h41 + 8'(k);
            tests_run++; if (to_uart_valid !== 1'b1 || to_uart_data !== exp || busy !== 1'b1 || grant_id !== 2'd2 || req_ready !== 4'b0100)
                begin tests_failed++; $display("FAIL single_beat%0d: got v=%b d=%h busy=%b gid=%0d rdy=%b expected 1 %h 1 2 0100", k, to_uart_valid, to_uart_data, busy, grant_id, req_ready, exp); end
        end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || to_uart_valid !== 1'b0)
            begin tests_failed++; $display("FAIL single_release: got busy=%b valid=%b expected 0 0", busy, to_uart_valid); end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_d [10] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h12, 8'h13};
        int         exp_g [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int start;
        bit ok;
        reset_dut();
        start = log_n;
        load(0, 2, 8'h10, 1'b1);
        load(0, 2, 8'h12, 1'b1);
        load(1, 2, 8'h20, 1'b1);
        load(2, 2, 8'h30, 1'b1);
        load(3, 2, 8'h40, 1'b1);
        wait_log(start + 10, 200, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rr_timeout: got %0d beats expected 10", log_n - start); end
        for (int j = 0; j < 10; j++) begin
            tests_run++; if (log_d[start+j] !== exp_d[j] || log_g[start+j] != exp_g[j])
                begin tests_failed++; $display("FAIL rr_beat%0d: got %h/gid%0d expected %h/gid%0d", j, log_d[start+j], log_g[start+j], exp_d[j], exp_g[j]); end
        end
        wait_idle(20, ok);
        tests_run++; if (log_n - start != 10) begin tests_failed++; $display("FAIL rr_count: got %0d expected 10", log_n - start); end
    endtask

    task automatic test_burst_limit;
        logic [7:0] ed;
        int eg;
        int start;
        bit ok;
        reset_dut();
        start = log_n;
        load(1, 70, 8'h00, 1'b0);
        load(2, 1, 8'hA0, 1'b1);
        load(3, 1, 8'hB0, 1'b1);
        wait_log(start + 72, 400, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL burst_timeout: got %0d beats expected 72", log_n - start); end
        for (int j = 0; j < 72; j++) begin
            if (j < 64)       begin ed = 8'(j);     eg = 1; end
            else if (j == 64) begin ed = 8'hA0;     eg = 2; end
            else if (j == 65) begin ed = 8'hB0;     eg = 3; end
            else              begin ed = 8'(j - 2); eg = 1; end
            tests_run++; if (log_d[start+j] !== ed || log_g[start+j] != eg)
                begin tests_failed++; $display("FAIL burst_beat%0d: got %h/gid%0d expected %h/gid%0d", j, log_d[start+j], log_g[start+j], ed, eg); end
        end
        repeat (20) @(negedge clk);
        tests_run++; if (busy !== 1'b1 || grant_id !== 2'd1 || to_uart_valid !== 1'b0)
            begin tests_failed++; $display("FAIL burst_hold: got busy=%b gid=%0d valid=%b expected 1 1 0", busy, grant_id, to_uart_valid); end
        tests_run++; if (log_n - start != 72) begin tests_failed++; $display("FAIL burst_count: got %0d expected 72", log_n - start); end
    endtask

    task automatic test_ready_toggle;
        logic       rdy   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h11, 8'h11, 8'h12};
        logic [3:0] exp_r [5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
        logic [7:0] exp_l [4] = '{8'h10, 8'h11, 8'h12, 8'h20};
        int start;
        bit ok;
        reset_dut();
        start = log_n;
        load(0, 3, 8'h10, 1'b1);
        load(1, 1, 8'h20, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk); #1 to_uart_ready = rdy[k];
            end
            @(negedge clk);
            tests_run++; if (to_uart_valid !== 1'b1 || to_uart_data !== exp_d[k] || req_ready !== exp_r[k])
                begin tests_failed++; $display("FAIL toggle_cyc%0d: got v=%b d=%h rdy=%b expected 1 %h %b", k, to_uart_valid, to_uart_data, req_ready, exp_d[k], exp_r[k]); end
        end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL toggle_release: got busy=%b expected 0", busy); end
        @(negedge clk);
        tests_run++; if (busy !== 1'b1 || grant_id !== 2'd1 || to_uart_data !== 8'h20 || req_ready !== 4'b0010)
            begin tests_failed++; $display("FAIL toggle_next: got busy=%b gid=%0d d=%h rdy=%b expected 1 1 20 0010", busy, grant_id, to_uart_data, req_ready); end
        #1 wait_idle(20, ok);
        tests_run++; if (log_n - start != 4) begin tests_failed++; $display("FAIL toggle_count: got %0d expected 4", log_n - start); end
        for (int j = 0; j < 4; j++) begin
            tests_run++; if (log_d[start+j] !== exp_l[j])
                begin tests_failed++; $display("FAIL toggle_log%0d: got %h expected %h", j, log_d[start+j], exp_l[j]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_d [5] = '{8'h31, 8'h50, 8'h51, 8'h60, 8'h70};
        int         exp_g [5] = '{1, 2, 2, 0, 3};
        int start;
        bit ok;
        reset_dut();
        start = log_n;
        load(1, 1, 8'h31, 1'b1);
        wait_log(start + 1, 20, ok);
        wait_idle(20, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rmid_setup_timeout: got busy=%b expected 0", busy); end
        load(2, 5, 8'h50, 1'b1);
        @(negedge clk);
        tests_run++; if (to_uart_data !== 8'h50 || grant_id !== 2'd2) begin tests_failed++; $display("FAIL rmid_b0: got %h/gid%0d expected 50/gid2", to_uart_data, grant_id); end
        @(negedge clk);
        tests_run++; if (to_uart_data !== 8'h51 || grant_id !== 2'd2) begin tests_failed++; $display("FAIL rmid_b1: got %h/gid%0d expected 51/gid2", to_uart_data, grant_id); end
        @(posedge clk); #2;
        reset = 1'b1;
        s_len[2] = s_pos[2];
        @(negedge clk);
        tests_run++; if (to_uart_valid !== 1'b0 || busy !== 1'b0)
            begin tests_failed++; $display("FAIL rmid_during: got valid=%b busy=%b expected 0 0", to_uart_valid, busy); end
        @(negedge clk);
        tests_run++; if (to_uart_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0)
            begin tests_failed++; $display("FAIL rmid_after: got valid=%b busy=%b gid=%0d expected 0 0 0", to_uart_valid, busy, grant_id); end
        #1;
        load(0, 1, 8'h60, 1'b1);
        load(3, 1, 8'h70, 1'b1);
        @(posedge clk); #2 reset = 1'b0;
        wait_log(start + 5, 40, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rmid_timeout: got %0d beats expected 5", log_n - start); end
        for (int j = 0; j < 5; j++) begin
            tests_run++; if (log_d[start+j] !== exp_d[j] || log_g[start+j] != exp_g[j])
                begin tests_failed++; $display("FAIL rmid_log%0d: got %h/gid%0d expected %h/gid%0d", j, log_d[start+j], log_g[start+j], exp_d[j], exp_g[j]); end
        end
        wait_idle(20, ok);
    endtask

    task automatic test_wrap;
        logic [7:0] exp_d [5] = '{8'hD0, 8'hD1, 8'hE0, 8'hE1, 8'hE2};
        int         exp_g [5] = '{3, 3, 0, 1, 2};
        int start;
        bit ok;
        reset_dut();
        start = log_n;
        load(3, 2, 8'hD0, 1'b1);
        @(negedge clk); #1;
        load(0, 1, 8'hE0, 1'b1);
        load(1, 1, 8'hE1, 1'b1);
        load(2, 1, 8'hE2, 1'b1);
        #1;
        tests_run++; if (busy !== 1'b1 || grant_id !== 2'd3 || req_ready !== 4'b1000)
            begin tests_failed++; $display("FAIL wrap_no_preempt: got busy=%b gid=%0d rdy=%b expected 1 3 1000", busy, grant_id, req_ready); end
        wait_log(start + 5, 60, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL wrap_timeout: got %0d beats expected 5", log_n - start); end
        for (int j = 0; j < 5; j++) begin
            tests_run++; if (log_d[start+j] !== exp_d[j] || log_g[start+j] != exp_g[j])
                begin tests_failed++; $display("FAIL wrap_log%0d: got %h/gid%0d expected %h/gid%0d", j, log_d[start+j], log_g[start+j], exp_d[j], exp_g[j]); end
        end
        wait_idle(20, ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        to_uart_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_limit();
        test_ready_toggle();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
